pc_unit: RTL and testbench

Parametrised program-counter unit for the core's fetch stage. It holds the current fetch address and advances it by a fixed increment each cycle. It also supports stall, branch/jump redirect, trap entry, and a halt/resume mode for debug. Misaligned redirect targets are rejected and reported instead of being loaded.

---
 rtl/pc_unit.sv | 117 +++++++++++
 tb/tb_pc_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, stall, redirect,
// trap entry and debug halt/resume, with misaligned redirects rejected.
module pc_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INC          = 4,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus,
    output logic            pc_valid,
    output logic            halted,
    output logic            misalign_err,
    output logic [XLEN-1:0] bad_addr
);

    localparam logic [XLEN-1:0] INC_W =
        XLEN'(INC);
    localparam logic [XLEN-1:0] LOW_MASK =
        XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] bad_d;
    logic            err_d;
    logic            rd_ok;
    logic [XLEN-1:0] trap_pc;

    assign pc_plus = pc_out + INC_W;
    assign rd_ok   = (redirect_pc & LOW_MASK) == '0;
    assign trap_pc = trap_vector & ~LOW_MASK;

    // Next state, next PC and redirect-rejection bookkeeping.
    always_comb begin
        state_d = state;
        pc_d    = pc_out;
        err_d   = 1'b0;
        bad_d   = bad_addr;
        unique case (state)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (trap_en) begin
                    pc_d = trap_pc;
                end else begin
                    if (redirect_en && rd_ok) begin
                        pc_d = redirect_pc;
                    end else if (redirect_en) begin
                        err_d = 1'b1;
                        bad_d = redirect_pc;
                    end else if (!stall && !halt_req) begin
                        pc_d = pc_plus;
                    end
                    if (halt_req) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                if (trap_en) begin
                    pc_d    = trap_pc;
                    state_d = RUN;
                end else begin
                    if (redirect_en && rd_ok) begin
                        pc_d = redirect_pc;
                    end else if (redirect_en) begin
                        err_d = 1'b1;
                        bad_d = redirect_pc;
                    end
                    if (resume) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and registered outputs; status flags follow the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= BOOT;
            pc_out       <= RESET_VECTOR;
            pc_valid     <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            bad_addr     <= '0;
        end else begin
            state        <= state_d;
            pc_out       <= pc_d;
            pc_valid     <= (state_d == RUN);
            halted       <= (state_d == HALT);
            misalign_err <= err_d;
            bad_addr     <= bad_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with RESET_VECTOR=0x100, INC=4,
// ALIGN_BITS=2; each task drives one scenario and checks inline.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        trap_en;
    logic [31:0] trap_vector;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc_out;
    logic [31:0] pc_plus;
    logic        pc_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] bad_addr;

    int checks = 0;
    int fails  = 0;

    pc_unit #(
        .XLEN        (32),
        .RESET_VECTOR(32'h100),
        .INC         (4),
        .ALIGN_BITS  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .trap_en     (trap_en),
        .trap_vector (trap_vector),
        .halt_req    (halt_req),
        .resume      (resume),
        .pc_out      (pc_out),
        .pc_plus     (pc_plus),
        .pc_valid    (pc_valid),
        .halted      (halted),
        .misalign_err(misalign_err),
        .bad_addr    (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        trap_en     = 1'b0;
        trap_vector = '0;
        halt_req    = 1'b0;
        resume      = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [3];
        exp_seq = '{32'h100, 32'h104, 32'h108};
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pc_out, pc_valid, halted, misalign_err, bad_addr}
            !== {32'h100, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL reset_vals: pc=%h v=%b h=%b e=%b bad=%h",
                     pc_out, pc_valid, halted, misalign_err, bad_addr);
        end
        reset = 1'b0;
        #2;
        checks++;
        if ({pc_out, pc_valid} !== {32'h100, 1'b0}) begin
            fails++;
            $display("FAIL boot_cycle: pc=%h v=%b want 100/0",
                     pc_out, pc_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({pc_out, pc_valid} !== {exp_seq[i], 1'b1}) begin
                fails++;
                $display("FAIL seq%0d: pc=%h v=%b want %h/1",
                         i, pc_out, pc_valid, exp_seq[i]);
            end
        end
        checks++;
        if (pc_plus !== 32'h10C) begin
            fails++;
            $display("FAIL pc_plus: got %h want 10c", pc_plus);
        end
    endtask

    task automatic test_stall_redirect();
        redirect_en = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_en = 1'b0;
        checks++;
        if (pc_out !== 32'h200) begin
            fails++;
            $display("FAIL redir_200: got %h want 200", pc_out);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({pc_out, pc_valid} !== {32'h200, 1'b1}) begin
                fails++;
                $display("FAIL stall%0d: pc=%h v=%b want 200/1",
                         i, pc_out, pc_valid);
            end
        end
        stall       = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 32'h4000;
        tick();
        redirect_en = 1'b0;
        checks++;
        if (pc_out !== 32'h4000) begin
            fails++;
            $display("FAIL redir_4000: got %h want 4000", pc_out);
        end
    endtask

    task automatic test_misalign();
        redirect_en = 1'b1;
        redirect_pc = 32'h4002;
        tick();
        redirect_en = 1'b0;
        checks++;
        if ({pc_out, misalign_err, bad_addr}
            !== {32'h4000, 1'b1, 32'h4002}) begin
            fails++;
            $display("FAIL misalign: pc=%h e=%b bad=%h want 4000/1/4002",
                     pc_out, misalign_err, bad_addr);
        end
        tick();
        checks++;
        if ({pc_out, misalign_err, bad_addr}
            !== {32'h4004, 1'b0, 32'h4002}) begin
            fails++;
            $display("FAIL misalign_clr: pc=%h e=%b bad=%h want 4004/0/4002",
                     pc_out, misalign_err, bad_addr);
        end
        tick();
        checks++;
        if (pc_out !== 32'h4008) begin
            fails++;
            $display("FAIL misalign_inc: got %h want 4008", pc_out);
        end
    endtask

    task automatic test_trap_priority();
        trap_en     = 1'b1;
        trap_vector = 32'h8000_0003;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_5001;
        halt_req    = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if ({pc_out, pc_valid, halted, misalign_err}
            !== {32'h8000_0000, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL trap_win: pc=%h v=%b h=%b e=%b want 80000000/1/0/0",
                     pc_out, pc_valid, halted, misalign_err);
        end
        tick();
        checks++;
        if (pc_out !== 32'h8000_0004) begin
            fails++;
            $display("FAIL trap_inc: got %h want 80000004", pc_out);
        end
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++;
        if ({pc_out, pc_valid, halted}
            !== {32'h8000_0004, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL halt_enter: pc=%h v=%b h=%b want 80000004/0/1",
                     pc_out, pc_valid, halted);
        end
        stall = 1'b1;
        tick();
        stall = 1'b0;
        checks++;
        if ({pc_out, pc_valid, halted}
            !== {32'h8000_0004, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL halt_hold: pc=%h v=%b h=%b want 80000004/0/1",
                     pc_out, pc_valid, halted);
        end
        redirect_en = 1'b1;
        redirect_pc = 32'h1000;
        tick();
        checks++;
        if ({pc_out, pc_valid, halted}
            !== {32'h1000, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL halt_setpc: pc=%h v=%b h=%b want 1000/0/1",
                     pc_out, pc_valid, halted);
        end
        redirect_pc = 32'h1001;
        tick();
        redirect_en = 1'b0;
        checks++;
        if ({pc_out, halted, misalign_err, bad_addr}
            !== {32'h1000, 1'b1, 1'b1, 32'h1001}) begin
            fails++;
            $display("FAIL halt_misal: pc=%h h=%b e=%b bad=%h want 1000/1/1/1001",
                     pc_out, halted, misalign_err, bad_addr);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        checks++;
        if ({pc_out, pc_valid, halted, misalign_err}
            !== {32'h1000, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL resume: pc=%h v=%b h=%b e=%b want 1000/1/0/0",
                     pc_out, pc_valid, halted, misalign_err);
        end
        tick();
        checks++;
        if (pc_out !== 32'h1004) begin
            fails++;
            $display("FAIL resume_inc: got %h want 1004", pc_out);
        end
        halt_req = 1'b1;
        tick();
        halt_req    = 1'b0;
        trap_en     = 1'b1;
        trap_vector = 32'h0000_0302;
        resume      = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if ({pc_out, pc_valid, halted}
            !== {32'h300, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL halt_trap: pc=%h v=%b h=%b want 300/1/0",
                     pc_out, pc_valid, halted);
        end
    endtask

    task automatic test_wrap();
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_en = 1'b0;
        checks++;
        if ({pc_out, pc_plus} !== {32'hFFFF_FFFC, 32'h0}) begin
            fails++;
            $display("FAIL wrap_pre: pc=%h plus=%h want fffffffc/0",
                     pc_out, pc_plus);
        end
        tick();
        checks++;
        if ({pc_out, pc_plus, pc_valid}
            !== {32'h0, 32'h4, 1'b1}) begin
            fails++;
            $display("FAIL wrap: pc=%h plus=%h v=%b want 0/4/1",
                     pc_out, pc_plus, pc_valid);
        end
    endtask

    task automatic test_async_reset();
        tick();
        tick();
        #2;
        redirect_en = 1'b1;
        redirect_pc = 32'h2000;
        reset       = 1'b1;
        #1;
        checks++;
        if ({pc_out, pc_valid, halted, misalign_err, bad_addr}
            !== {32'h100, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL async_rst: pc=%h v=%b h=%b e=%b bad=%h",
                     pc_out, pc_valid, halted, misalign_err, bad_addr);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({pc_out, pc_valid} !== {32'h100, 1'b1}) begin
            fails++;
            $display("FAIL boot_ignore: pc=%h v=%b want 100/1",
                     pc_out, pc_valid);
        end
        redirect_en = 1'b0;
        tick();
        checks++;
        if (pc_out !== 32'h104) begin
            fails++;
            $display("FAIL post_rst: got %h want 104", pc_out);
        end
    endtask

    initial begin
        test_reset();
        test_stall_redirect();
        test_misalign();
        test_trap_priority();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
